// File: rtl/foc_mul_pipe_param.sv
// Parametrised pipelined multiplier for the FOC datapath: registered operands, full product, delay, scaled output.
// Optional FOC_MUL_SAT_EN adds round-half-up and clamp in the final stage.
module foc_mul_pipe_param #(
    parameter int A_W       = 15,
    parameter int B_W       = 15,
    parameter int SIGNED_A  = 0,
    parameter int SIGNED_B  = 0,
    parameter int NUM_STAGE = 4,
    parameter int SHIFT     = 0,
    parameter int OUT_W     = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [A_W-1:0]   din0,
    input  logic [B_W-1:0]   din1,
    output logic             out_valid,
    output logic [OUT_W-1:0] dout,
    output logic             sat
);
    localparam int PW = A_W + B_W;
    localparam int XW = PW + 2;
    localparam bit PS = (SIGNED_A != 0) || (SIGNED_B != 0);

    logic [A_W-1:0]        a_r;
    logic [B_W-1:0]        b_r;
    logic [NUM_STAGE:1]    vld_pipe;
    logic signed [PW:0]    a_x, b_x, prod_x;
    logic [PW-1:0]         p_comb, p_last;
    logic signed [XW-1:0]  p_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r      <= '0;
            b_r      <= '0;
            vld_pipe <= '0;
        end else if (ce) begin
            a_r      <= din0;
            b_r      <= din1;
            vld_pipe <= {vld_pipe[NUM_STAGE-1:1], in_valid};
        end
    end

    // One extra bit lets unsigned operands ride a signed multiply; the low PW bits are exact.
    assign a_x    = {{(PW+1-A_W){(SIGNED_A != 0) & a_r[A_W-1]}}, a_r};
    assign b_x    = {{(PW+1-B_W){(SIGNED_B != 0) & b_r[B_W-1]}}, b_r};
    assign prod_x = a_x * b_x;
    assign p_comb = prod_x[PW-1:0];

    generate
        if (NUM_STAGE == 2) begin : g_no_preg
            assign p_last = p_comb;
        end else begin : g_preg
            logic [PW-1:0] pp [NUM_STAGE-2];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < NUM_STAGE-2; k++) pp[k] <= '0;
                end else if (ce) begin
                    pp[0] <= p_comb;
                    for (int k = 1; k < NUM_STAGE-2; k++) pp[k] <= pp[k-1];
                end
            end
            assign p_last = pp[NUM_STAGE-3];
        end
    endgenerate

    assign p_x       = {{2{PS & p_last[PW-1]}}, p_last};
    assign out_valid = vld_pipe[NUM_STAGE];

`ifdef FOC_MUL_SAT_EN
    localparam logic signed [XW-1:0] ONE = 1;
    localparam int                   RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [XW-1:0] RND = (SHIFT > 0) ? (ONE <<< RSH) : '0;
    localparam logic signed [XW-1:0] HI  = PS ? (ONE <<< (OUT_W-1)) - ONE : (ONE <<< OUT_W) - ONE;
    localparam logic signed [XW-1:0] LO  = PS ? -(ONE <<< (OUT_W-1)) : '0;

    logic signed [XW-1:0] s_x;
    logic [OUT_W-1:0]     s_clamp;
    logic                 s_sat;
    logic                 sat_r;

    always_comb begin
        s_x     = (p_x + RND) >>> SHIFT;
        s_clamp = s_x[OUT_W-1:0];
        s_sat   = 1'b0;
        if (s_x > HI) begin
            s_clamp = HI[OUT_W-1:0];
            s_sat   = 1'b1;
        end else if (s_x < LO) begin
            s_clamp = LO[OUT_W-1:0];
            s_sat   = 1'b1;
        end
    end

    // Bubbles clear sat but leave dout holding the last result.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout  <= '0;
            sat_r <= 1'b0;
        end else if (ce) begin
            if (vld_pipe[NUM_STAGE-1]) begin
                dout  <= s_clamp;
                sat_r <= s_sat;
            end else begin
                sat_r <= 1'b0;
            end
        end
    end
    assign sat = sat_r;
`else
    always_ff @(posedge clk) begin
        if (reset)
            dout <= '0;
        else if (ce && vld_pipe[NUM_STAGE-1])
            dout <= OUT_W'(p_x >>> SHIFT);
    end
    assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_foc_mul_pipe_param.sv
// Scoreboard bench for foc_mul_pipe_param: four configurations, directed vectors, ce-cycle-accurate latency check.
module tb_foc_mul_pipe_param;
    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        iv [NI];
    logic [31:0] d0 [NI];
    logic [31:0] d1 [NI];
    logic        ov [NI];
    logic        st [NI];
    logic [63:0] dv [NI];
    logic [29:0] q0;
    logic [31:0] q1;
    logic [15:0] q2;
    logic [29:0] q3;

    always #5 clk = ~clk;

    foc_mul_pipe_param u0 (.clk(clk), .reset(reset), .ce(ce), .in_valid(iv[0]),
        .din0(d0[0][14:0]), .din1(d1[0][14:0]), .out_valid(ov[0]), .dout(q0), .sat(st[0]));
    foc_mul_pipe_param #(.A_W(16), .B_W(16), .SIGNED_A(1), .SIGNED_B(1), .OUT_W(32)) u1 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(iv[1]),
        .din0(d0[1][15:0]), .din1(d1[1][15:0]), .out_valid(ov[1]), .dout(q1), .sat(st[1]));
    foc_mul_pipe_param #(.A_W(16), .B_W(16), .SIGNED_A(1), .SIGNED_B(1), .SHIFT(15), .OUT_W(16)) u2 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(iv[2]),
        .din0(d0[2][15:0]), .din1(d1[2][15:0]), .out_valid(ov[2]), .dout(q2), .sat(st[2]));
    foc_mul_pipe_param #(.SHIFT(1), .NUM_STAGE(2)) u3 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(iv[3]),
        .din0(d0[3][14:0]), .din1(d1[3][14:0]), .out_valid(ov[3]), .dout(q3), .sat(st[3]));

    assign dv[0] = 64'(q0);
    assign dv[1] = 64'(q1);
    assign dv[2] = 64'(q2);
    assign dv[3] = 64'(q3);

    typedef struct {
        logic [63:0] val;
        logic        s;
        int          due;
    } exp_t;

    exp_t sb [NI][$];
    int   compared = 0;
    int   mismatched = 0;
    int   cnt = 0;
    bit   adv = 1'b0;

    function automatic int lat(input int i);
        return (i == 3) ? 2 : 4;
    endfunction

    // ce-qualified cycle counter: expected arrival is counted in enabled edges only
    always @(posedge clk) begin
        if (reset) begin
            cnt <= 0;
            adv <= 1'b0;
        end else begin
            adv <= ce;
            if (ce) cnt <= cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset && adv) begin
            for (int i = 0; i < NI; i++) begin
                exp_t e;
                if (ov[i]) begin
                    compared++;
                    if (sb[i].size() == 0) begin
                        mismatched++;
                        $display("FAIL spurious_valid inst%0d: got dout=%0h, expected no output", i, dv[i]);
                    end else begin
                        e = sb[i].pop_front();
                        if (dv[i] !== e.val || st[i] !== e.s || cnt != e.due) begin
                            mismatched++;
                            $display("FAIL result inst%0d: got dout=%0h sat=%0b cyc=%0d, expected dout=%0h sat=%0b cyc=%0d",
                                     i, dv[i], st[i], cnt, e.val, e.s, e.due);
                        end
                    end
                end else if (sb[i].size() > 0 && sb[i][0].due <= cnt) begin
                    compared++;
                    mismatched++;
                    e = sb[i].pop_front();
                    $display("FAIL missing_valid inst%0d: got out_valid=0 at cyc=%0d, expected dout=%0h", i, cnt, e.val);
                end
            end
        end
    end

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] ev, input logic es);
        exp_t e;
        iv[i] = 1'b1;
        d0[i] = a;
        d1[i] = b;
        e.val = ev;
        e.s   = es;
        e.due = cnt + lat(i);
        sb[i].push_back(e);
        @(negedge clk);
        iv[i] = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drain();
        int left;
        for (int n = 0; n < 30; n++) begin
            left = 0;
            for (int i = 0; i < NI; i++) left += sb[i].size();
            if (left == 0) break;
            @(negedge clk);
        end
        left = 0;
        for (int i = 0; i < NI; i++) left += sb[i].size();
        if (left != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", left);
            for (int i = 0; i < NI; i++) sb[i].delete();
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0;
            d0[i] = '0;
            d1[i] = '0;
        end
        ce = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_valid%0d", i), 64'(ov[i]), 64'd0);
            chk($sformatf("reset_dout%0d", i), dv[i], 64'd0);
        end
        @(negedge clk);

        // defaults: max unsigned operands, plus zero and a small value
        issue(0, 32'd32767, 32'd32767, 64'd1073676289, 1'b0);
        issue(0, 32'd0, 32'd12345, 64'd0, 1'b0);
        issue(0, 32'd12345, 32'd2, 64'd24690, 1'b0);
        drain();

        // stall mid-flight: three back-to-back samples, ce low for 3 cycles
        issue(0, 32'd1, 32'd1, 64'd1, 1'b0);
        issue(0, 32'd2, 32'd2, 64'd4, 1'b0);
        issue(0, 32'd3, 32'd3, 64'd9, 1'b0);
        ce = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b1;
        drain();

        // reset mid-flight with ce low: reset must still win
        issue(0, 32'd100, 32'd100, 64'd10000, 1'b0);
        issue(0, 32'd200, 32'd200, 64'd40000, 1'b0);
        issue(0, 32'd300, 32'd300, 64'd90000, 1'b0);
        reset = 1'b1;
        ce = 1'b0;
        for (int i = 0; i < NI; i++) sb[i].delete();
        @(negedge clk);
        reset = 1'b0;
        ce = 1'b1;
        for (int n = 0; n < 3; n++) begin
            chk("post_reset_valid", 64'(ov[0]), 64'd0);
            chk("post_reset_dout", dv[0], 64'd0);
            @(negedge clk);
        end
        issue(0, 32'd5, 32'd7, 64'd35, 1'b0);
        drain();

        // signed 16x16, full 32-bit output
        issue(1, 32'hFFFF_FFFD, 32'd5, 64'h0000_0000_FFFF_FFF1, 1'b0);
        issue(1, 32'h0000_8000, 32'h0000_8000, 64'd1073741824, 1'b0);
        issue(1, 32'h0000_7FFF, 32'h0000_8000, 64'h0000_0000_C000_8000, 1'b0);
        drain();

        // signed Q15 with SHIFT=15, OUT_W=16
`ifdef FOC_MUL_SAT_EN
        issue(2, 32'h0000_8000, 32'h0000_8000, 64'h7FFF, 1'b1);
        issue(2, 32'd16384, 32'd16384, 64'd8192, 1'b0);
        issue(2, 32'hFFFF_FFFD, 32'd5, 64'h0000, 1'b0);
`else
        issue(2, 32'h0000_8000, 32'h0000_8000, 64'h8000, 1'b0);
        issue(2, 32'd16384, 32'd16384, 64'd8192, 1'b0);
        issue(2, 32'hFFFF_FFFD, 32'd5, 64'hFFFF, 1'b0);
`endif
        drain();

        // unsigned SHIFT=1, two-stage pipe, bubble between samples
`ifdef FOC_MUL_SAT_EN
        issue(3, 32'd3, 32'd1, 64'd2, 1'b0);
        @(negedge clk);
        issue(3, 32'd5, 32'd1, 64'd3, 1'b0);
        chk("bubble_valid", 64'(ov[3]), 64'd0);
        chk("bubble_hold", dv[3], 64'd2);
        issue(3, 32'd32767, 32'd32767, 64'd536838145, 1'b0);
`else
        issue(3, 32'd3, 32'd1, 64'd1, 1'b0);
        @(negedge clk);
        issue(3, 32'd5, 32'd1, 64'd2, 1'b0);
        chk("bubble_valid", 64'(ov[3]), 64'd0);
        chk("bubble_hold", dv[3], 64'd1);
        issue(3, 32'd32767, 32'd32767, 64'd536838144, 1'b0);
`endif
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
